// File: rtl/int_ctrl_pkg.sv
// Shared constants and types for the interrupt controller: register offsets,
// claim-word layout and the controller state encoding.
package int_ctrl_pkg;
  localparam int MAX_SRC = 6;
  localparam int IDX_W = 3;
  localparam int CLAIM_VALID_BIT = 31;

  localparam logic [3:0] OFF_PEND  = 4'h0;
  localparam logic [3:0] OFF_MASK  = 4'h4;
  localparam logic [3:0] OFF_MODE  = 4'h8;
  localparam logic [3:0] OFF_CLAIM = 4'hC;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_NEST = 1'b1
  } state_t;
endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-first priority encoder: reports whether any request is set and
// the index of the lowest set bit (0 when none).
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int N = MAX_SRC
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);
  always_comb begin
    valid = 1'b0;
    idx = '0;
    // Scan downward so the lowest set index is the one left standing.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/int_ctrl.sv
// Memory-mapped interrupt controller: pending/mask/mode registers, claim/EOI
// nesting with a priority threshold, registered request lines to the CPU.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int          NSRC = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F40
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src_irq,
  input  logic [31:0]     bus_addr,
  input  logic [31:0]     bus_wdata,
  input  logic [3:0]      bus_byteen,
  input  logic            bus_re,
  output logic [31:0]     bus_rdata,
  output logic [NSRC-1:0] hw_int,
  output logic            irq_any
);
  logic [NSRC-1:0] pend_reg, mask_reg, mode_reg, isr_reg, src_q_reg, hw_int_reg;
  logic [NSRC-1:0] pend_next, mask_next, mode_next, isr_next, hw_int_next;
  logic [NSRC-1:0] w1c, set_vec, claim_vec, eoi_clr;
  logic            primed_reg;
  state_t          state_reg, state_next;
  logic [IDX_W-1:0] thr_next;

  logic             hit, wr, claim;
  logic [3:0]       off;
  logic             c_valid, isr_valid;
  logic [IDX_W-1:0] c_idx, isr_idx;
  logic             unused_bits;

  assign unused_bits = ^bus_wdata[31:NSRC];

  assign hit = (bus_addr[31:4] == BASE_ADDR[31:4]) && (bus_addr[1:0] == 2'b00);
  assign off = bus_addr[3:0];
  assign wr  = hit && (bus_byteen != 4'b0000);
  assign claim = bus_re && hit && (off == OFF_CLAIM) && c_valid;

  int_prio_enc #(.N(NSRC)) u_claim_enc (
    .req   (pend_reg & mask_reg),
    .valid (c_valid),
    .idx   (c_idx)
  );

  int_prio_enc #(.N(NSRC)) u_thr_enc (
    .req   (isr_next),
    .valid (isr_valid),
    .idx   (isr_idx)
  );

  assign w1c       = (wr && off == OFF_PEND && bus_byteen[0]) ? bus_wdata[NSRC-1:0] : '0;
  assign mask_next = (wr && off == OFF_MASK && bus_byteen[0]) ? bus_wdata[NSRC-1:0] : mask_reg;
  assign mode_next = (wr && off == OFF_MODE && bus_byteen[0]) ? bus_wdata[NSRC-1:0] : mode_reg;

  // Edge detection is suppressed until src_q holds a real sample after reset.
  assign set_vec = (mode_next & src_irq & ~src_q_reg & {NSRC{primed_reg}})
                 | (~mode_next & src_irq);

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    assign claim_vec[gi] = claim && (c_idx == IDX_W'(gi));
    assign eoi_clr[gi]   = wr && (off == OFF_CLAIM) && (bus_wdata[4:0] == 5'(gi));
    assign hw_int_next[gi] = pend_next[gi] & mask_next[gi] & (gi < int'(thr_next));
  end

  // Level sources keep PEND on claim; only edge sources consume it.
  assign pend_next = (pend_reg & ~w1c & ~(claim_vec & mode_reg)) | set_vec;
  assign isr_next  = (isr_reg | claim_vec) & ~eoi_clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (isr_valid)  state_next = ST_NEST;
      ST_NEST: if (!isr_valid) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    thr_next = (state_next == ST_NEST) ? isr_idx : IDX_W'(NSRC);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_reg   <= '0;
      mask_reg   <= '0;
      mode_reg   <= '0;
      isr_reg    <= '0;
      src_q_reg  <= '0;
      hw_int_reg <= '0;
      primed_reg <= 1'b0;
    end else begin
      pend_reg   <= pend_next;
      mask_reg   <= mask_next;
      mode_reg   <= mode_next;
      isr_reg    <= isr_next;
      src_q_reg  <= src_irq;
      hw_int_reg <= hw_int_next;
      primed_reg <= 1'b1;
    end
  end

  always_comb begin
    bus_rdata = '0;
    if (hit) begin
      case (off)
        OFF_PEND: bus_rdata[NSRC-1:0] = pend_reg;
        OFF_MASK: bus_rdata[NSRC-1:0] = mask_reg;
        OFF_MODE: bus_rdata[NSRC-1:0] = mode_reg;
        OFF_CLAIM: begin
          bus_rdata[CLAIM_VALID_BIT] = c_valid;
          bus_rdata[4:0] = 5'(c_idx);
        end
        default: bus_rdata = '0;
      endcase
    end
  end

  assign hw_int  = hw_int_reg;
  assign irq_any = |hw_int_reg;
endmodule

// File: tb/tb_int_ctrl.sv
// Directed self-checking bench for int_ctrl with hand-computed expectations.
module tb_int_ctrl;
  localparam logic [31:0] A_PEND  = 32'h0000_7F40;
  localparam logic [31:0] A_MASK  = 32'h0000_7F44;
  localparam logic [31:0] A_MODE  = 32'h0000_7F48;
  localparam logic [31:0] A_CLAIM = 32'h0000_7F4C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [5:0]  src_irq = '0;
  logic [31:0] bus_addr = '0;
  logic [31:0] bus_wdata = '0;
  logic [3:0]  bus_byteen = '0;
  logic        bus_re = 1'b0;
  logic [31:0] bus_rdata;
  logic [5:0]  hw_int;
  logic        irq_any;

  int checks = 0;
  int passed = 0;

  int_ctrl #(.NSRC(6), .BASE_ADDR(32'h0000_7F40)) dut (
    .clk        (clk),
    .reset      (reset),
    .src_irq    (src_irq),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_byteen (bus_byteen),
    .bus_re     (bus_re),
    .bus_rdata  (bus_rdata),
    .hw_int     (hw_int),
    .irq_any    (irq_any)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_addr = a;
    bus_wdata = d;
    bus_byteen = 4'hF;
    tick();
    bus_byteen = 4'h0;
    $display("write addr=%h data=%h", a, d);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus_addr = a;
    bus_re = 1'b0;
    #1 d = bus_rdata;
    $display("read  addr=%h data=%h", a, d);
  endtask

  task automatic claim_rd(output logic [31:0] d);
    bus_addr = A_CLAIM;
    bus_re = 1'b1;
    #1 d = bus_rdata;
    @(posedge clk);
    @(negedge clk);
    bus_re = 1'b0;
    $display("claim data=%h hw_int=%h", d, hw_int);
  endtask

  task automatic pulse(input logic [5:0] s);
    src_irq = s;
    tick();
    src_irq = '0;
    $display("pulse src=%h hw_int=%h", s, hw_int);
  endtask

  task automatic chk_hw(input string name, input logic [5:0] exp);
    checks++;
    if (hw_int !== exp) $display("FAIL %s hw_int got=%h exp=%h", name, hw_int, exp);
    else passed++;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    src_irq = 6'h3F;
    #1;
    checks++;
    if (hw_int !== 6'h00 || irq_any !== 1'b0)
      $display("FAIL reset_out hw_int=%h irq_any=%b exp=00/0", hw_int, irq_any);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    tick();
    rd(A_PEND, d);
    checks++;
    if (d !== 32'h3F) $display("FAIL reset_level_pend got=%h exp=%h", d, 32'h3F);
    else passed++;
    rd(A_MODE, d);
    checks++;
    if (d !== 32'h0) $display("FAIL reset_mode got=%h exp=0", d);
    else passed++;
    chk_hw("reset_masked", 6'h00);
    src_irq = '0;
    wr(A_PEND, 32'h3F);
    rd(A_PEND, d);
    checks++;
    if (d !== 32'h0) $display("FAIL reset_w1c got=%h exp=0", d);
    else passed++;
  endtask

  task automatic test_edge_w1c();
    logic [31:0] d;
    wr(A_MODE, 32'h01);
    wr(A_MASK, 32'h01);
    pulse(6'h01);
    rd(A_PEND, d);
    checks++;
    if (d !== 32'h01) $display("FAIL edge_pend got=%h exp=01", d);
    else passed++;
    chk_hw("edge_hw", 6'h01);
    wr(A_PEND, 32'h01);
    chk_hw("w1c_hw", 6'h00);
  endtask

  task automatic test_priority();
    logic [31:0] d;
    wr(A_MODE, 32'h3F);
    wr(A_MASK, 32'h3F);
    pulse(6'h14);
    chk_hw("prio_both", 6'h14);
    checks++;
    if (irq_any !== 1'b1) $display("FAIL prio_irq_any got=%b exp=1", irq_any);
    else passed++;
    claim_rd(d);
    checks++;
    if (d !== 32'h8000_0002) $display("FAIL prio_claim2 got=%h exp=80000002", d);
    else passed++;
    chk_hw("prio_thr2", 6'h00);
    wr(A_CLAIM, 32'd2);
    chk_hw("prio_eoi2", 6'h10);
    rd(A_CLAIM, d);
    checks++;
    if (d !== 32'h8000_0004) $display("FAIL prio_claim4 got=%h exp=80000004", d);
    else passed++;
    claim_rd(d);
    wr(A_CLAIM, 32'd4);
    rd(A_PEND, d);
    checks++;
    if (d !== 32'h0) $display("FAIL prio_clean got=%h exp=0", d);
    else passed++;
  endtask

  task automatic test_nesting();
    logic [31:0] d;
    pulse(6'h08);
    claim_rd(d);
    checks++;
    if (d !== 32'h8000_0003) $display("FAIL nest_claim3 got=%h exp=80000003", d);
    else passed++;
    pulse(6'h02);
    chk_hw("nest_src1", 6'h02);
    claim_rd(d);
    checks++;
    if (d !== 32'h8000_0001) $display("FAIL nest_claim1 got=%h exp=80000001", d);
    else passed++;
    chk_hw("nest_in1", 6'h00);
    pulse(6'h04);
    chk_hw("nest_src2_blocked", 6'h00);
    wr(A_CLAIM, 32'd1);
    chk_hw("nest_eoi1_thr3", 6'h04);
    wr(A_PEND, 32'h04);
    pulse(6'h20);
    chk_hw("nest_src5_blocked", 6'h00);
    wr(A_CLAIM, 32'd0);
    wr(A_CLAIM, 32'd9);
    chk_hw("nest_bad_eoi", 6'h00);
    wr(A_CLAIM, 32'd3);
    chk_hw("nest_idle", 6'h20);
    wr(A_PEND, 32'h20);
    claim_rd(d);
    checks++;
    if (d !== 32'h0) $display("FAIL nest_claim_none got=%h exp=0", d);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    pulse(6'h01);
    tick();
    src_irq = 6'h01;
    wr(A_PEND, 32'h01);
    rd(A_PEND, d);
    checks++;
    if (d !== 32'h01) $display("FAIL set_wins got=%h exp=01", d);
    else passed++;
    src_irq = '0;
    wr(A_PEND, 32'h01);
    wr(32'h0000_7F50, 32'h0);
    wr(32'h0000_7F45, 32'h0);
    rd(A_MASK, d);
    checks++;
    if (d !== 32'h3F) $display("FAIL outside_write got=%h exp=3F", d);
    else passed++;
    rd(32'h0000_7F50, d);
    checks++;
    if (d !== 32'h0) $display("FAIL outside_read got=%h exp=0", d);
    else passed++;
    rd(32'h0000_7F46, d);
    checks++;
    if (d !== 32'h0) $display("FAIL misaligned_read got=%h exp=0", d);
    else passed++;
  endtask

  task automatic test_reset_mid_nest();
    logic [31:0] d;
    pulse(6'h08);
    claim_rd(d);
    pulse(6'h02);
    chk_hw("rst_pre", 6'h02);
    src_irq = 6'h08;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (hw_int !== 6'h00 || irq_any !== 1'b0)
      $display("FAIL rst_async hw_int=%h irq_any=%b exp=00/0", hw_int, irq_any);
    else passed++;
    rd(A_MASK, d);
    checks++;
    if (d !== 32'h0) $display("FAIL rst_mask got=%h exp=0", d);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    wr(A_MODE, 32'h3F);
    rd(A_PEND, d);
    checks++;
    if (d !== 32'h0) $display("FAIL rst_no_edge got=%h exp=0", d);
    else passed++;
    src_irq = '0;
    tick();
    pulse(6'h08);
    rd(A_PEND, d);
    checks++;
    if (d !== 32'h08) $display("FAIL rst_edge_after got=%h exp=08", d);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_edge_w1c();
    test_priority();
    test_nesting();
    test_back_to_back();
    test_reset_mid_nest();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Memory-mapped interrupt controller between the interrupt sources and the mips core's 6-bit hardware-interrupt input. Sources are Timer0, Timer1, the external interrupt pin and spare lines.
- Latches pending requests, applies mask and edge/level mode, and resolves fixed priority (index 0 highest).
- Supports claim/EOI nesting, so that only sources of higher priority than the one in service reach the CPU.
- Sits on the bridge's data-bus side beside the timers.

Parameters:
- NSRC, 6: number of interrupt sources (1..6); drives hw_int width.
- BASE_ADDR, 32'h0000_7F40: word-aligned base of the 16-byte register window.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- src_irq  in  NSRC  raw interrupt lines, synchronous to clk.
- bus_addr  in  32  bridge byte address.
- bus_wdata  in  32  write data.
- bus_byteen  in  4  byte enables; any bit set with an address hit is a write.
- bus_re  in  1  read strobe, one cycle per load.
- bus_rdata  out  32  read data, combinational from bus_addr.
- hw_int  out  NSRC  registered interrupt requests to the CPU HWInt field.
- irq_any  out  1  OR of hw_int.

Behaviour:
- Register map (offset, all word-wide; byte lanes honoured on RW fields):
  - 0x0 PEND: read returns pending; write-1-to-clear.
  - 0x4 MASK: RW, 1 = enabled.
  - 0x8 MODE: RW, 1 = edge, 0 = level.
  - 0xC CLAIM/EOI:
    - Read returns {valid[31], 26'b0, idx[4:0]} of the highest-priority PEND&MASK source; valid=0 and idx=0 if none.
    - Write value idx = EOI.
- Access outside the window, or with bus_addr[1:0] != 0: no effect; rdata = 0.
- Reset value of every output and register is 0: PEND, MASK, MODE, ISR (in-service), src_q, hw_int, irq_any.
- Edge source: PEND bit sets on src_irq & ~src_q (src_q is last cycle's sample).
- Level source: PEND bit sets every cycle src_irq is high.
- Set and W1C clear in the same cycle: set wins.
- Two states per controller:
  - IDLE: ISR == 0.
  - NEST: ISR != 0.
- Claim (bus_re && hit 0xC && valid):
  - At the edge, set ISR[idx].
  - Clear PEND[idx] if edge mode. Level stays pending until the line drops and software clears it.
  - State moves IDLE->NEST or stays NEST.
- Claim with valid=0: no state change.
- EOI write with idx < NSRC and ISR[idx]=1: clear ISR[idx]. NEST->IDLE when ISR becomes 0.
- EOI of a non-in-service or out-of-range idx: ignored.
- Priority threshold T = index of the lowest set ISR bit, or NSRC if ISR == 0.
- hw_int updates at each edge: hw_int[i] <= pend_next[i] & mask_next[i] & (i < T_next).
  - This gives one-cycle latency: source edge sampled at edge n means hw_int is high after edge n.
- MASK write takes effect on hw_int at the same edge.
- Read and claim while a new source sets in the same cycle: bus_rdata reflects pre-edge state; the new source stays pending.
- Reset mid-claim: everything returns to 0 asynchronously; the first edge after release resamples src_irq into src_q without generating an edge.
- NSRC < 6: the unused upper hw_int/register bits of the CPU-facing field read 0 and ignore writes.

Decomposition:
- Package int_ctrl_pkg holds:
  - register offsets (OFF_PEND, OFF_MASK, OFF_MODE, OFF_CLAIM);
  - CLAIM_VALID_BIT = 31;
  - max-source constant 6.
- One sub-module, int_prio_enc: combinational NSRC-bit lowest-index-first priority encoder returning {valid, idx}.
- Instantiated twice:
  - once for the claim path on PEND&MASK;
  - once for threshold T on ISR.

Test Plan:
- Reset with src_irq=6'h3F, release, MASK=0 -> PEND shows level bits set the next cycle, MODE=0, hw_int stays 0.
- MODE=0x01, MASK=0x01, 1-cycle pulse on src_irq[0] -> PEND=0x01 and hw_int=0x01 one edge later; W1C 0x1 -> hw_int=0 next edge.
- MASK=0x3F, edge pulses on sources 2 and 4 together -> CLAIM read returns 0x8000_0002; hw_int drops to 0x00 (threshold 2); EOI 2 -> hw_int=0x10, CLAIM returns 0x8000_0004.
- Nesting: claim source 3, then pulse source 1 -> hw_int=0x02; claim 1 -> hw_int=0; EOI 1 -> threshold back to 3; EOI 3 -> state IDLE.
- Same-cycle set and W1C on an edge source -> PEND bit stays 1; write to 0x7F50 -> no register changes, rdata=0.
- Assert reset mid-NEST with ISR=0x08 -> all outputs 0 immediately; no spurious edge on release with src_irq held high.
